// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: four-master round-robin bus arbiter with active-low request,
// grant and ready handshakes. An owner that holds the bus long enough can be
// preempted, but only on a transaction-completion (m_rdy_ low) cycle.

module bus_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic [7:0] preempt_cnt
);

  // Hold limit in the width of the hold counter; legal values fit in 8 bits.
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  holdCnt_q, holdCnt_d;
  logic [7:0]  preemptCnt_q, preemptCnt_d;
  logic        busy_q, busy_d;

  logic [3:0]  reqVec;
  logic [3:0]  otherReq;
  logic [1:0]  pick;
  logic        canPreempt;

  // Requests are active-low on the pins; work with active-high internally.
  assign reqVec = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Everybody requesting except the current owner.
  assign otherReq = reqVec & ~(4'b0001 << owner_q);

  // Round-robin search starting just after the most recently granted master
  // and ending on that master itself, so it has the lowest priority.
  function automatic logic [1:0] rrPick(input logic [3:0] reqs,
                                        input logic [1:0] from);
    logic [1:0] result;
    logic [1:0] cand;
    result = from;
    for (int k = 4; k >= 1; k--) begin
      cand = from + 2'(k);
      if (reqs[cand]) begin
        result = cand;
      end
    end
    return result;
  endfunction

  // Candidate for the next grant; in OWNED the owner is excluded from the pool.
  always_comb begin
    pick = 2'd0;
    if (state_q == IDLE) begin
      pick = rrPick(reqVec, last_q);
    end else begin
      pick = rrPick(otherReq, last_q);
    end
  end

  // Forced handover: owner still wants the bus, has used its hold budget,
  // someone else is waiting and the current transfer is completing.
  assign canPreempt = (state_q == OWNED) && reqVec[owner_q] &&
                      (holdCnt_q == HOLD_LIM) && (|otherReq) && !m_rdy_;

  // Next-state, grant, hold and preemption bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_d       = last_q;
    holdCnt_d    = holdCnt_q;
    preemptCnt_d = preemptCnt_q;

    case (state_q)
      IDLE: begin
        if (|reqVec) begin
          state_d   = OWNED;
          grant_d   = 4'b0001 << pick;
          owner_d   = pick;
          last_d    = pick;
          holdCnt_d = 8'd0;
        end
      end

      OWNED: begin
        if (!reqVec[owner_q]) begin
          if (|otherReq) begin
            grant_d   = 4'b0001 << pick;
            owner_d   = pick;
            last_d    = pick;
            holdCnt_d = 8'd0;
          end else begin
            state_d   = IDLE;
            grant_d   = 4'b0000;
            holdCnt_d = 8'd0;
          end
        end else if (canPreempt) begin
          grant_d   = 4'b0001 << pick;
          owner_d   = pick;
          last_d    = pick;
          holdCnt_d = 8'd0;
          if (preemptCnt_q != 8'hFF) begin
            preemptCnt_d = preemptCnt_q + 8'd1;
          end
        end else if (holdCnt_q < HOLD_LIM) begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // busy is registered alongside the grants so the two always agree.
  assign busy_d = |grant_d;

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 4'b0000;
      owner_q      <= 2'd0;
      last_q       <= 2'd3;
      holdCnt_q    <= 8'd0;
      preemptCnt_q <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      holdCnt_q    <= holdCnt_d;
      preemptCnt_q <= preemptCnt_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_grnt_    = ~grant_q[0];
  assign m1_grnt_    = ~grant_q[1];
  assign m2_grnt_    = ~grant_q[2];
  assign m3_grnt_    = ~grant_q[3];
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign preempt_cnt = preemptCnt_q;

endmodule
